// File: rtl/fft_peak_reader.sv
// fft_peak_reader: consumer end of the FFT magnitude write interface.
// Each frame of bin magnitudes is captured into a ping-pong buffer. The
// completed frame is then scanned for the strongest bin in [MIN_BIN, MAX_BIN],
// and the block reports the peak bin, its magnitude and a note-present flag.
// A registered read port gives display logic access to the last completed frame.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   haddr/hdata/hwe   bin write interface (one bin per cycle while hwe=1)
//   rd_addr/rd_data   display read port, 1-cycle latency, held while busy
//   busy              scan in progress (SCAN or DONE)
//   peak_valid        one-cycle pulse when the peak outputs update
//   peak_bin/peak_mag strongest bin of the last scanned frame
//   note_present      peak_mag >= THRESH
//   overrun           sticky; a frame completed while busy
//   second_bin/_mag   runner-up bin (only with FFT_PEAK_SECOND_EN, else 0)
//
// Optional feature macro: FFT_PEAK_SECOND_EN (runner-up tracking).

module fft_peak_reader #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MIN_BIN = 2,
   parameter int unsigned MAX_BIN = 1023,
   parameter logic [15:0] THRESH  = 16'h0100
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [11:0]       haddr,
   input  logic [DATA_W-1:0] hdata,
   input  logic              hwe,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              peak_valid,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [DATA_W-1:0] peak_mag,
   output logic              note_present,
   output logic              overrun,
   output logic [ADDR_W-1:0] second_bin,
   output logic [DATA_W-1:0] second_mag
);

   localparam int unsigned DEPTH      = 2 ** ADDR_W;
   localparam int unsigned MEM_DEPTH  = 2 * DEPTH;
   localparam logic [ADDR_W-1:0] MIN_A = ADDR_W'(MIN_BIN);
   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_BIN);
   localparam logic [11:0] LAST_HADDR  = 12'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_wb;
   logic                r_busy;
   logic                r_peak_valid;
   logic [ADDR_W-1:0]   r_peak_bin;
   logic [DATA_W-1:0]   r_peak_mag;
   logic                r_note_present;
   logic                r_overrun;
   logic [DATA_W-1:0]   r_rd_data;

   // scan pipeline: address issue stage, then compare stage one cycle later
   logic                r_issue;
   logic [ADDR_W-1:0]   r_scan_addr;
   logic                r_cmp_vld;
   logic [ADDR_W-1:0]   r_cmp_idx;
   logic [DATA_W-1:0]   r_scan_q;

   logic [ADDR_W-1:0]   r_max_bin;
   logic [DATA_W-1:0]   r_max_mag;
   logic [ADDR_W-1:0]   w_nxt_max_bin;
   logic [DATA_W-1:0]   w_nxt_max_mag;

`ifdef FFT_PEAK_SECOND_EN
   logic [ADDR_W-1:0]   r_sec_bin;
   logic [DATA_W-1:0]   r_sec_mag;
   logic [ADDR_W-1:0]   w_nxt_sec_bin;
   logic [DATA_W-1:0]   w_nxt_sec_mag;
   logic [ADDR_W-1:0]   r_second_bin;
   logic [DATA_W-1:0]   r_second_mag;
`endif

   logic [DATA_W-1:0]   r_mem [0:MEM_DEPTH-1];

   logic                w_wr_ok;
   logic                w_fc;
   logic                w_last_cmp;

   // Writes above the frame range are dropped; the last bin closes the frame.
   assign w_wr_ok    = hwe && ((haddr >> ADDR_W) == 12'd0);
   assign w_fc       = w_wr_ok && (haddr == LAST_HADDR);
   assign w_last_cmp = r_cmp_vld && (r_cmp_idx == MAX_A);

   // Ping-pong buffer: write bank r_wb, scan reads the other bank.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[{r_wb, haddr[ADDR_W-1:0]}] <= hdata;
      end
      r_scan_q <= r_mem[{~r_wb, r_scan_addr}];
   end

   // Running max (and runner-up) including the sample currently on r_scan_q.
   always_comb begin
      w_nxt_max_bin = r_max_bin;
      w_nxt_max_mag = r_max_mag;
`ifdef FFT_PEAK_SECOND_EN
      w_nxt_sec_bin = r_sec_bin;
      w_nxt_sec_mag = r_sec_mag;
`endif
      if (r_cmp_vld) begin
         // strict greater-than keeps the lowest index on a tie
         if (r_scan_q > r_max_mag) begin
            w_nxt_max_bin = r_cmp_idx;
            w_nxt_max_mag = r_scan_q;
`ifdef FFT_PEAK_SECOND_EN
            w_nxt_sec_bin = r_max_bin;
            w_nxt_sec_mag = r_max_mag;
`endif
         end
`ifdef FFT_PEAK_SECOND_EN
         else if (r_scan_q > r_sec_mag) begin
            w_nxt_sec_bin = r_cmp_idx;
            w_nxt_sec_mag = r_scan_q;
         end
`endif
      end
   end

   // Control FSM, scan pipeline and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_wb           <= 1'b0;
         r_busy         <= 1'b0;
         r_peak_valid   <= 1'b0;
         r_peak_bin     <= '0;
         r_peak_mag     <= '0;
         r_note_present <= 1'b0;
         r_overrun      <= 1'b0;
         r_rd_data      <= '0;
         r_issue        <= 1'b0;
         r_scan_addr    <= MIN_A;
         r_cmp_vld      <= 1'b0;
         r_cmp_idx      <= MIN_A;
         r_max_bin      <= MIN_A;
         r_max_mag      <= '0;
`ifdef FFT_PEAK_SECOND_EN
         r_sec_bin      <= MIN_A;
         r_sec_mag      <= '0;
         r_second_bin   <= '0;
         r_second_mag   <= '0;
`endif
      end else begin
         r_peak_valid <= 1'b0;

         // display port freezes while a scan owns the completed bank
         if (!r_busy) begin
            r_rd_data <= r_mem[{~r_wb, rd_addr}];
         end

         r_max_bin <= w_nxt_max_bin;
         r_max_mag <= w_nxt_max_mag;
`ifdef FFT_PEAK_SECOND_EN
         r_sec_bin <= w_nxt_sec_bin;
         r_sec_mag <= w_nxt_sec_mag;
`endif

         r_cmp_vld <= r_issue;
         r_cmp_idx <= r_scan_addr;
         if (r_issue) begin
            r_scan_addr <= r_scan_addr + ADDR_W'(1);
            if (r_scan_addr == MAX_A) begin
               r_issue <= 1'b0;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_fc) begin
                  r_wb        <= ~r_wb;
                  r_state     <= S_SCAN;
                  r_busy      <= 1'b1;
                  r_issue     <= 1'b1;
                  r_scan_addr <= MIN_A;
                  r_cmp_vld   <= 1'b0;
                  r_max_bin   <= MIN_A;
                  r_max_mag   <= '0;
`ifdef FFT_PEAK_SECOND_EN
                  r_sec_bin   <= MIN_A;
                  r_sec_mag   <= '0;
`endif
               end
            end
            S_SCAN: begin
               if (w_fc) begin
                  r_overrun <= 1'b1;
               end
               if (w_last_cmp) begin
                  r_peak_bin     <= w_nxt_max_bin;
                  r_peak_mag     <= w_nxt_max_mag;
                  r_note_present <= (w_nxt_max_mag >= THRESH);
                  r_peak_valid   <= 1'b1;
                  r_state        <= S_DONE;
`ifdef FFT_PEAK_SECOND_EN
                  r_second_bin   <= w_nxt_sec_bin;
                  r_second_mag   <= w_nxt_sec_mag;
`endif
               end
            end
            S_DONE: begin
               if (w_fc) begin
                  r_overrun <= 1'b1;
               end
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data      = r_rd_data;
   assign busy         = r_busy;
   assign peak_valid   = r_peak_valid;
   assign peak_bin     = r_peak_bin;
   assign peak_mag     = r_peak_mag;
   assign note_present = r_note_present;
   assign overrun      = r_overrun;

`ifdef FFT_PEAK_SECOND_EN
   assign second_bin   = r_second_bin;
   assign second_mag   = r_second_mag;
`else
   assign second_bin   = '0;
   assign second_mag   = '0;
`endif

endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed testbench for fft_peak_reader with default parameters
// (1024 bins, scan range 2..1023, THRESH 16'h0100).

module tb_fft_peak_reader;

   logic        clk;
   logic        reset_n;
   logic [11:0] haddr;
   logic [15:0] hdata;
   logic        hwe;
   logic [9:0]  rd_addr;
   logic [15:0] rd_data;
   logic        busy;
   logic        peak_valid;
   logic [9:0]  peak_bin;
   logic [15:0] peak_mag;
   logic        note_present;
   logic        overrun;
   logic [9:0]  second_bin;
   logic [15:0] second_mag;

   int vectors    = 0;
   int miscompares = 0;

   logic [15:0] frame [0:1023];

   fft_peak_reader dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .haddr        (haddr),
      .hdata        (hdata),
      .hwe          (hwe),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .peak_valid   (peak_valid),
      .peak_bin     (peak_bin),
      .peak_mag     (peak_mag),
      .note_present (note_present),
      .overrun      (overrun),
      .second_bin   (second_bin),
      .second_mag   (second_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_frame(input logic [15:0] v);
      for (int i = 0; i < 1024; i++) frame[i] = v;
   endtask

   // Drives bins 0..1023; the last drive (haddr=1023) is cycle T.
   task automatic send_frame();
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         haddr = 12'(i);
         hdata = frame[i];
         hwe   = 1'b1;
      end
   endtask

   // Counts cycles after T from k0; peak_valid is expected in cycle T+1024.
   task automatic wait_peak(input int k0, input string tag,
                            input logic [9:0] eb, input logic [15:0] em, input logic en);
      int k;
      bit seen;
      seen = 1'b0;
      k = k0;
      while (k <= 1100 && !seen) begin
         @(negedge clk);
         if (k == k0) begin
            hwe   = 1'b0;
            haddr = 12'd0;
            hdata = 16'd0;
            chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
         end
         if (peak_valid) seen = 1'b1;
         else k++;
      end
      chk({tag, "_latency"}, 32'(k), 32'd1024);
      chk({tag, "_bin"}, 32'(peak_bin), 32'(eb));
      chk({tag, "_mag"}, 32'(peak_mag), 32'(em));
      chk({tag, "_note"}, 32'(note_present), 32'(en));
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(peak_valid), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic rd_check(input logic [9:0] a, input logic [15:0] e, input string tag);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      chk(tag, 32'(rd_data), 32'(e));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(peak_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_bin"}, 32'(peak_bin), 32'd0);
      chk({tag, "_mag"}, 32'(peak_mag), 32'd0);
      chk({tag, "_note"}, 32'(note_present), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun), 32'd0);
      chk({tag, "_rd"}, 32'(rd_data), 32'd0);
      chk({tag, "_sbin"}, 32'(second_bin), 32'd0);
      chk({tag, "_smag"}, 32'(second_mag), 32'd0);
   endtask

   initial begin
      int pv_count;
      reset_n = 1'b0;
      haddr   = 12'd0;
      hdata   = 16'd0;
      hwe     = 1'b0;
      rd_addr = 10'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // single strong bin over a flat floor
      fill_frame(16'h0010);
      frame[100] = 16'h0800;
      send_frame();
      wait_peak(1, "basic", 10'd100, 16'h0800, 1'b1);
      chk("basic_ovr", 32'(overrun), 32'd0);
      rd_check(10'd100, 16'h0800, "basic_rd100");
      rd_check(10'd5, 16'h0010, "basic_rd5");

      // tie: lowest index wins
      fill_frame(16'h0000);
      frame[50] = 16'h0500;
      frame[60] = 16'h0500;
      send_frame();
      wait_peak(1, "tie", 10'd50, 16'h0500, 1'b1);

      // bins below MIN_BIN ignored, peak below threshold
      fill_frame(16'h0000);
      frame[0] = 16'hFFFF;
      frame[1] = 16'hFFFF;
      frame[7] = 16'h00FF;
      send_frame();
      wait_peak(1, "lowbins", 10'd7, 16'h00FF, 1'b0);

      // all-zero frame still pulses with MIN_BIN
      fill_frame(16'h0000);
      send_frame();
      wait_peak(1, "zero", 10'd2, 16'h0000, 1'b0);

      // overrun: second frame completes 200 cycles into the scan
      fill_frame(16'h0020);
      frame[300] = 16'h0700;
      send_frame();
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         haddr = 12'(823 + k);
         hdata = 16'h0055;
         hwe   = 1'b1;
      end
      wait_peak(201, "ovr", 10'd300, 16'h0700, 1'b1);
      chk("ovr_flag", 32'(overrun), 32'd1);
      repeat (5) @(negedge clk);
      rd_check(10'd300, 16'h0700, "ovr_rd300");
      rd_check(10'd1000, 16'h0020, "ovr_rd1000");
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // reset at scan midpoint aborts the scan
      fill_frame(16'h0000);
      frame[500] = 16'h0400;
      send_frame();
      @(negedge clk);
      hwe = 1'b0;
      repeat (510) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      reset_n = 1'b1;
      pv_count = 0;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         if (peak_valid) pv_count++;
      end
      chk("midrst_no_pulse", 32'(pv_count), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);

      // fresh frame after reset
      fill_frame(16'h0001);
      frame[900] = 16'h1234;
      send_frame();
      wait_peak(1, "post", 10'd900, 16'h1234, 1'b1);
      rd_check(10'd900, 16'h1234, "post_rd900");
      rd_check(10'd500, 16'h0001, "post_rd500");
      chk("post_ovr", 32'(overrun), 32'd0);

      // runner-up tracking
      fill_frame(16'h0000);
      frame[30] = 16'h0300;
      frame[40] = 16'h0900;
      frame[80] = 16'h0600;
      send_frame();
      wait_peak(1, "second", 10'd40, 16'h0900, 1'b1);
`ifdef FFT_PEAK_SECOND_EN
      chk("second_bin", 32'(second_bin), 32'd80);
      chk("second_mag", 32'(second_mag), 32'h0600);
`else
      chk("second_bin", 32'(second_bin), 32'd0);
      chk("second_mag", 32'(second_mag), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fft_peak_reader.md
Name: fft_peak_reader

Overview:
- Consumer end of the FFT magnitude write interface (haddr/hdata/hwe) driven by the FFT processing block.
- Captures each frame of bin magnitudes into a ping-pong buffer.
- Scans the completed frame for the strongest bin in a configurable band and reports peak bin, magnitude and note-present flag.
- Provides a registered random-access read port so display logic can fetch the last completed frame.

Parameters:
- ADDR_W, 10, log2 of bins per frame; frame = 2^ADDR_W bins.
- DATA_W, 16, magnitude width; must equal hdata width.
- MIN_BIN, 2, first bin scanned (skips DC).
- MAX_BIN, 1023, last bin scanned; MIN_BIN <= MAX_BIN <= 2^ADDR_W-1.
- THRESH, 16'h0100, minimum peak magnitude for note_present.

Ports:
- clk  in  1  system clock (104 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- haddr  in  12  FFT bin write address
- hdata  in  16  FFT bin magnitude
- hwe  in  1  write strobe; one bin per cycle when high
- rd_addr  in  ADDR_W  display read address
- rd_data  out  16  bin magnitude of last completed frame; 1-cycle latency
- busy  out  1  high while a scan is in progress
- peak_valid  out  1  one-cycle pulse when peak outputs update
- peak_bin  out  ADDR_W  index of max bin in [MIN_BIN, MAX_BIN]
- peak_mag  out  16  magnitude at peak_bin
- note_present  out  1  peak_mag >= THRESH
- overrun  out  1  sticky; a frame completed while busy
- second_bin  out  ADDR_W  see Optional Feature
- second_mag  out  16  see Optional Feature

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; write bank wb=0. RAM contents are not cleared. Reset mid-scan aborts the scan and produces no peak_valid.
- Buffer: two banks of 2^ADDR_W x 16. Writes go to bank wb when hwe=1 and haddr[11:ADDR_W]==0. Writes outside that range are ignored.
- Frame complete event (FC): hwe=1 and haddr == 2^ADDR_W-1, sampled in cycle T.
- FC in IDLE: the write in cycle T lands in bank wb; at T+1, wb toggles and the state enters SCAN on bank ~wb (the frame just written).
- FC in SCAN or DONE: overrun<=1 and wb is not toggled. The next frame overwrites the same write bank, and the scan in progress is unaffected.
- State machine IDLE -> SCAN -> DONE -> IDLE. busy=1 in SCAN and DONE.
- SCAN issues read addresses MIN_BIN..MAX_BIN, one per cycle starting at T+1 (N = MAX_BIN-MIN_BIN+1 cycles). RAM read latency is 1 cycle; the comparator runs 1 cycle behind.
- Compare rule: strict greater-than, so on a tie the lowest index wins. The running max initialises to (MIN_BIN, 0).
- DONE occurs at cycle T+N+2. In that cycle peak_bin, peak_mag and note_present update and peak_valid=1 for exactly that cycle. Outputs hold until the next DONE.
- All-zero frame: peak_bin=MIN_BIN, peak_mag=0, note_present=0, peak_valid still pulses.
- Display port: rd_data <= bank[~wb][rd_addr] one cycle after rd_addr, valid only when busy=0. While busy=1, rd_data holds its last value.
- Writes continue into bank wb during a scan with no stall; the block never back-pressures the writer.

Optional Feature:
- Macro: FFT_PEAK_SECOND_EN.
- Defined: also track the runner-up. If x > max, then second <= max and max <= x; else if x > second, second <= x. second_bin and second_mag update at DONE alongside peak outputs. Init second = (MIN_BIN, 0).
- Undefined: second_bin and second_mag are tied to 0 and no tracking logic is built. Port list is unchanged.

Test Plan:
- Reset, write frame with bin 100=16'h0800, all else 16'h0010; FC at T -> peak_valid at T+1024, peak_bin=100, peak_mag=16'h0800, note_present=1, busy falls after DONE.
- Bins 50 and 60 both 16'h0500, all others 0 -> peak_bin=50 (tie, lowest index wins).
- Bin 0 and bin 1 = 16'hFFFF, bin 7 = 16'h00FF, rest 0 -> peak_bin=7, peak_mag=16'h00FF, note_present=0 (below THRESH; bins below MIN_BIN ignored).
- Second FC 200 cycles after the first -> overrun=1 (sticky); first scan completes normally. Write-to-display check after idle: rd_addr=100 returns the first frame's value next cycle.
- Assert reset_n=0 at scan midpoint -> outputs 0, no peak_valid. New frame after release scans correctly into bank 0/1 ordering from wb=0.
- With FFT_PEAK_SECOND_EN: bins 30=16'h0300, 40=16'h0900, 80=16'h0600 -> peak_bin=40, second_bin=80, second_mag=16'h0600. Without the macro: second outputs stay 0.
